forth_dbus_uart: RTL and testbench

FORTH_DBUS_UART -- requirements
Module: forth_dbus_uart

---
 rtl/forth_dbus_uart.sv | 118 +++++++++++
 tb/tb_forth_dbus_uart.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/forth_dbus_uart.sv
// forth_dbus_uart: CPU data bus with 240-word RAM, a TX FIFO and an 8N1 UART
// transmitter mapped at 0xF0 (TXDATA) and 0xF1 (STATUS).
module forth_dbus_uart #(
    parameter int WIDTH        = 16,
    parameter int DADDR_WIDTH  = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DADDR_WIDTH-1:0] daddr,
    input  logic [WIDTH-1:0]       ddata_write,
    input  logic                   dwrite,
    output logic [WIDTH-1:0]       ddata_read,
    output logic                   txd
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [DADDR_WIDTH-1:0] A_RAM_END = DADDR_WIDTH'(240);
    localparam logic [DADDR_WIDTH-1:0] A_TX      = DADDR_WIDTH'(8'hF0);
    localparam logic [DADDR_WIDTH-1:0] A_ST      = DADDR_WIDTH'(8'hF1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [WIDTH-1:0] ram_q [0:239];
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;
    state_t           state_q, state_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic [WIDTH-1:0] rdata_q, rdata_d, status;
    logic             full, empty, push_req, push, pop, ovf_set, baud_end, st_wr;

    assign full     = cnt_q == CW'(FIFO_DEPTH);
    assign empty    = cnt_q == '0;
    assign push_req = dwrite && !reset && daddr == A_TX;
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && !push;
    assign st_wr    = dwrite && daddr == A_ST;
    assign baud_end = baud_q == BW'(CLKS_PER_BIT - 1);
    assign status   = WIDTH'({ovf_q, state_q != IDLE, empty, full});
    assign rdata_d  = daddr < A_RAM_END ? ram_q[daddr] : daddr == A_ST ? status : '0;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        baud_d  = (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = START;
                shift_d = fifo_q[rptr_q];
                txd_d   = 1'b0;
            end
            START: if (baud_end) begin
                state_d = DATA;
                bit_d   = '0;
                txd_d   = shift_q[0];
            end
            DATA: if (baud_end) begin
                state_d = bit_q == 3'd7 ? STOP : DATA;
                bit_d   = bit_q + 3'd1;
                shift_d = shift_q >> 1;
                txd_d   = bit_q == 3'd7 ? 1'b1 : shift_q[1];
            end
            STOP: if (baud_end) begin
                // Chain straight into the next frame so back-to-back bytes leave no idle gap.
                pop     = !empty;
                state_d = empty ? IDLE : START;
                shift_d = empty ? shift_q : fifo_q[rptr_q];
                txd_d   = empty;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            wptr_q  <= wptr_q + PW'(push);
            rptr_q  <= rptr_q + PW'(pop);
            cnt_q   <= cnt_q + CW'(push) - CW'(pop);
            ovf_q   <= ovf_set || (ovf_q && !st_wr);
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= ddata_write[7:0];
        if (dwrite && !reset && daddr < A_RAM_END) ram_q[daddr] <= ddata_write;
    end

    assign ddata_read = rdata_q;
    assign txd        = txd_q;
endmodule

// File: tb/tb_forth_dbus_uart.sv
// tb_forth_dbus_uart: randomized bench comparing the bus/UART against a
// frame-position reference model built from the memory map and 8N1 framing.
module tb_forth_dbus_uart;
    localparam int CPB  = 4;
    localparam int LAST = 10 * CPB - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  daddr = '0;
    logic [15:0] ddata_write = '0;
    logic        dwrite = 1'b0;
    logic [15:0] ddata_read;
    logic        txd;

    forth_dbus_uart #(.WIDTH(16), .DADDR_WIDTH(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .daddr(daddr), .ddata_write(ddata_write),
        .dwrite(dwrite), .ddata_read(ddata_read), .txd(txd)
    );

    always #5 clk = ~clk;

    logic [15:0] ram_m [240];
    logic [7:0]  q_m [$];
    logic [7:0]  cur_m;
    bit          busy_m, ovf_m;
    int          pos_m;
    logic [15:0] exp_rd;
    logic        exp_txd;
    int          checks = 0, errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a frame is 10*CPB cycles; the bit on the wire is frame bit pos/CPB.
    task automatic cyc(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
        bit pop, preq, set;
        @(negedge clk);
        reset = r; dwrite = w; daddr = a; ddata_write = d;
        if (r) begin
            exp_rd = '0; q_m.delete(); busy_m = 0; pos_m = 0; ovf_m = 0;
        end else begin
            exp_rd = a < 240 ? ram_m[a] : a == 8'hF1 ?
                     {12'h0, ovf_m, busy_m, q_m.size() == 0, q_m.size() == 4} : 16'h0;
            pop  = q_m.size() > 0 && (!busy_m || pos_m == LAST);
            preq = w && a == 8'hF0;
            set  = preq && q_m.size() == 4 && !pop;
            if (pop) begin
                cur_m = q_m.pop_front(); busy_m = 1; pos_m = 0;
            end else if (busy_m) begin
                if (pos_m == LAST) busy_m = 0; else pos_m++;
            end
            if (preq && !set) q_m.push_back(d[7:0]);
            ovf_m = set || (ovf_m && !(w && a == 8'hF1));
            if (w && a < 240) ram_m[a] = d;
        end
        exp_txd = !busy_m ? 1'b1 : (pos_m / CPB == 0) ? 1'b0 : (pos_m / CPB == 9) ? 1'b1 : cur_m[pos_m / CPB - 1];
        @(posedge clk);
        #1;
        check("rdata", ddata_read, exp_rd);
        check("txd", {15'h0, txd}, {15'h0, exp_txd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'hF1, 16'h0);
    endtask

    initial begin
        cyc(1, 0, 8'h00, 16'h0);
        check("reset_rdata", ddata_read, 16'h0000);
        check("reset_txd", {15'h0, txd}, 16'h0001);
        cyc(1, 0, 8'h00, 16'h0);
        for (int i = 0; i < 240; i++) cyc(0, 1, 8'(i), 16'($urandom));

        cyc(0, 1, 8'h10, 16'h1234);
        cyc(0, 0, 8'h10, 16'h0);
        check("ram_read", ddata_read, 16'h1234);
        cyc(0, 1, 8'h10, 16'hBEEF);
        check("ram_rd_during_wr", ddata_read, 16'h1234);
        cyc(0, 0, 8'h10, 16'h0);
        check("ram_new", ddata_read, 16'hBEEF);

        cyc(0, 1, 8'hF0, 16'h0041);
        cyc(0, 0, 8'hF1, 16'h0);
        check("tx_start_bit", {15'h0, txd}, 16'h0000);
        idle(44);
        check("status_after_frame", ddata_read, 16'h0002);

        for (int i = 1; i <= 6; i++) cyc(0, 1, 8'hF0, 16'(i));
        cyc(0, 0, 8'hF1, 16'h0);
        check("status_full_ovf", ddata_read & 16'h000B, 16'h0009);
        cyc(0, 1, 8'hF1, 16'h0);
        cyc(0, 0, 8'hF1, 16'h0);
        check("ovf_cleared", ddata_read & 16'h0008, 16'h0000);
        idle(5 * 40 + 10);

        for (int i = 0; i < 5; i++) cyc(0, 1, 8'hF0, 16'(8'h30 + i));
        for (int i = 0; i < 60; i++) begin
            if (busy_m && pos_m == LAST) break;
            cyc(0, 0, 8'hF1, 16'h0);
        end
        cyc(0, 1, 8'hF0, 16'h00AA);
        cyc(0, 0, 8'hF1, 16'h0);
        check("push_on_pop", ddata_read & 16'h0009, 16'h0001);
        idle(5 * 40 + 10);

        cyc(0, 1, 8'h20, 16'h5555);
        cyc(0, 1, 8'hF0, 16'h00A5);
        idle(17);
        cyc(1, 1, 8'h20, 16'hDEAD);
        check("reset_mid_frame_txd", {15'h0, txd}, 16'h0001);
        cyc(0, 0, 8'hF1, 16'h0);
        check("status_after_reset", ddata_read, 16'h0002);
        cyc(0, 0, 8'h20, 16'h0);
        check("ram_retained", ddata_read, 16'h5555);

        cyc(0, 0, 8'hF0, 16'h0);
        check("txdata_read", ddata_read, 16'h0000);
        cyc(0, 1, 8'hF7, 16'hFFFF);
        check("unmapped_read", ddata_read, 16'h0000);
        cyc(0, 0, 8'hF1, 16'h0);
        check("unmapped_write", ddata_read, 16'h0002);

        for (int i = 0; i < 3000; i++) begin
            int k;
            logic [7:0] a;
            k = $urandom_range(0, 9);
            a = k < 5 ? 8'($urandom_range(0, 15)) : k < 7 ? 8'hF0 : k == 7 ? 8'hF1 :
                k == 8 ? 8'($urandom_range(242, 255)) : 8'($urandom);
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, a, 16'($urandom));
        end
        idle(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
